// File: rtl/comm_defs_pkg.sv
// ============================================================================
// Module  : comm_defs_pkg
// Brief   : Shared UART-controller types, ASCII constants and hex helpers.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package comm_defs_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_5  = 8'h35;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_B  = 8'h42;
    localparam logic [7:0] ASCII_C  = 8'h43;
    localparam logic [7:0] ASCII_D  = 8'h44;
    localparam logic [7:0] ASCII_E  = 8'h45;
    localparam logic [7:0] ASCII_F  = 8'h46;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] ASCII_X  = 8'h78;

    typedef enum logic [1:0] {IDLE, BUS, RESP} seq_state_t;

    typedef enum logic [1:0] {DERR, WOK, RDAT, TMO} resp_type_t;

    function automatic logic [3:0] ascii_to_num(input logic [7:0] c);
        if (c >= ASCII_A && c <= ASCII_F)
            return 4'(c - ASCII_A + 8'd10);
        else
            return c[3:0];
    endfunction

    function automatic logic [7:0] num_to_ascii(input logic [3:0] v);
        if (v < 4'd10)
            return ASCII_0 + {4'd0, v};
        else
            return ASCII_A + {4'd0, v - 4'd10};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_sequencer_if.sv
// ============================================================================
// Module  : cmd_sequencer_if
// Brief   : Bus master port and UART transmit handshake of the sequencer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface cmd_sequencer_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata,
        output tx_data, tx_valid,
        input  tx_ready
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata,
        input  tx_data, tx_valid,
        output tx_ready
    );
endinterface

`default_nettype wire

// File: rtl/cmd_sequencer.sv
// ============================================================================
// Module  : cmd_sequencer
// Brief   : Executes one decoded command on the bus and streams the ASCII reply.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module cmd_sequencer
    import comm_defs_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sm_start,
    input  logic [31:0]            addr,
    input  logic [31:0]            wrdata,
    input  logic                   we,
    input  logic                   decode_err,
    input  logic [15:0]            err_code,
    cmd_sequencer_if.master        port,
    output logic                   busy,
    output logic                   cmd_dropped
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    seq_state_t  state;
    resp_type_t  resp_type;
    logic [15:0] err_q;
    logic [31:0] rdata_q;
    logic [15:0] tmo_cnt;
    logic [3:0]  byte_idx;

    // Response byte mux; evaluated with next-cycle values so tx_data stays registered.
    function automatic logic [7:0] resp_byte(input resp_type_t t, input logic [3:0] idx,
                                             input logic [31:0] rd, input logic [15:0] ec);
        logic [7:0] b;
        logic [5:0] sh;
        b  = 8'h00;
        sh = 6'd36 - {idx, 2'b00};
        case (t)
            DERR: case (idx)
                4'd0: b = ASCII_E;
                4'd1: b = ec[7:0];
                4'd2: b = ec[15:8];
                4'd3: b = ASCII_CR;
                4'd4: b = ASCII_LF;
                default: b = 8'h00;
            endcase
            WOK: case (idx)
                4'd0: b = ASCII_O;
                4'd1: b = ASCII_K;
                4'd2: b = ASCII_CR;
                4'd3: b = ASCII_LF;
                default: b = 8'h00;
            endcase
            RDAT: begin
                if (idx == 4'd0)       b = ASCII_0;
                else if (idx == 4'd1)  b = ASCII_X;
                else if (idx <= 4'd9)  b = num_to_ascii(4'(rd >> sh));
                else if (idx == 4'd10) b = ASCII_CR;
                else if (idx == 4'd11) b = ASCII_LF;
                else                   b = 8'h00;
            end
            TMO: case (idx)
                4'd0: b = ASCII_E;
                4'd1: b = ASCII_5;
                4'd2: b = ASCII_0;
                4'd3: b = ASCII_CR;
                4'd4: b = ASCII_LF;
                default: b = 8'h00;
            endcase
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [3:0] resp_last(input resp_type_t t);
        case (t)
            DERR:    return 4'd4;
            WOK:     return 4'd3;
            RDAT:    return 4'd11;
            TMO:     return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            resp_type      <= WOK;
            err_q          <= 16'd0;
            rdata_q        <= 32'd0;
            tmo_cnt        <= 16'd0;
            byte_idx       <= 4'd0;
            busy           <= 1'b0;
            cmd_dropped    <= 1'b0;
            port.bus_req   <= 1'b0;
            port.bus_we    <= 1'b0;
            port.bus_addr  <= 32'd0;
            port.bus_wdata <= 32'd0;
            port.tx_valid  <= 1'b0;
            port.tx_data   <= 8'd0;
        end else begin
            if (sm_start && state != IDLE)
                cmd_dropped <= 1'b1;

            case (state)
                IDLE: begin
                    if (sm_start) begin
                        port.bus_addr  <= addr;
                        port.bus_wdata <= wrdata;
                        port.bus_we    <= we;
                        err_q          <= err_code;
                        busy           <= 1'b1;
                        byte_idx       <= 4'd0;
                        if (decode_err) begin
                            resp_type     <= DERR;
                            state         <= RESP;
                            port.tx_valid <= 1'b1;
                            port.tx_data  <= resp_byte(DERR, 4'd0, rdata_q, err_code);
                        end else begin
                            state        <= BUS;
                            port.bus_req <= 1'b1;
                            tmo_cnt      <= 16'd0;
                        end
                    end
                end
                BUS: begin
                    // Ack is checked first so an ack in the final timeout cycle wins.
                    if (port.bus_ack) begin
                        port.bus_req  <= 1'b0;
                        port.tx_valid <= 1'b1;
                        state         <= RESP;
                        if (port.bus_we) begin
                            resp_type    <= WOK;
                            port.tx_data <= resp_byte(WOK, 4'd0, rdata_q, err_q);
                        end else begin
                            rdata_q      <= port.bus_rdata;
                            resp_type    <= RDAT;
                            port.tx_data <= resp_byte(RDAT, 4'd0, port.bus_rdata, err_q);
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        port.bus_req  <= 1'b0;
                        port.tx_valid <= 1'b1;
                        resp_type     <= TMO;
                        port.tx_data  <= resp_byte(TMO, 4'd0, rdata_q, err_q);
                        state         <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (port.tx_ready) begin
                        if (byte_idx == resp_last(resp_type)) begin
                            state         <= IDLE;
                            busy          <= 1'b0;
                            port.tx_valid <= 1'b0;
                            port.tx_data  <= 8'd0;
                            byte_idx      <= 4'd0;
                        end else begin
                            byte_idx     <= byte_idx + 4'd1;
                            port.tx_data <= resp_byte(resp_type, byte_idx + 4'd1, rdata_q, err_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
// ============================================================================
// Module  : tb_cmd_sequencer
// Brief   : Directed self-checking bench for cmd_sequencer (TIMEOUT_CYC = 8).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cmd_sequencer;
    import comm_defs_pkg::*;

    logic        clk;
    logic        rst;
    logic        sm_start;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic        we;
    logic        decode_err;
    logic [15:0] err_code;
    logic        busy;
    logic        cmd_dropped;

    int checks;
    int failures;

    logic [7:0] got [16];
    int ngot;
    int ncyc;
    int unstable;
    int saw_req;
    int bus_cnt;

    cmd_sequencer_if sif ();

    cmd_sequencer #(.TIMEOUT_CYC(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .sm_start    (sm_start),
        .addr        (addr),
        .wrdata      (wrdata),
        .we          (we),
        .decode_err  (decode_err),
        .err_code    (err_code),
        .port        (sif.master),
        .busy        (busy),
        .cmd_dropped (cmd_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic de, input logic [15:0] ec);
        sm_start   = 1'b1;
        we         = w;
        addr       = a;
        wrdata     = d;
        decode_err = de;
        err_code   = ec;
        tick();
        sm_start   = 1'b0;
        decode_err = 1'b0;
    endtask

    // Counts bus_req-high cycles, acking in cycle ack_at (0 = never).
    task automatic run_bus(input int ack_at);
        bus_cnt = 0;
        while (sif.bus_req === 1'b1 && bus_cnt < 40) begin
            bus_cnt++;
            sif.bus_ack = (bus_cnt == ack_at);
            tick();
        end
        sif.bus_ack = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready high one cycle in three.
    task automatic recv(input int n, input int mode);
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       rdy;
        ngot = 0; ncyc = 0; unstable = 0; saw_req = 0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        while (ngot < n && ncyc < 200) begin
            rdy = (mode == 0) ? 1'b1 : ((ncyc % 3) == 0);
            sif.tx_ready = rdy;
            if (sif.bus_req === 1'b1) saw_req++;
            if (prev_stall && sif.tx_data !== prev_data) unstable++;
            if (sif.tx_valid === 1'b1 && rdy) begin
                got[ngot] = sif.tx_data;
                ngot++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = (sif.tx_valid === 1'b1);
                prev_data  = sif.tx_data;
            end
            ncyc++;
            tick();
        end
        sif.tx_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        checks++;
        if ({sif.bus_req, sif.bus_we, sif.tx_valid, busy, cmd_dropped} !== 5'b0 ||
            sif.bus_addr !== 32'd0 || sif.bus_wdata !== 32'd0 || sif.tx_data !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b we=%b valid=%b busy=%b drop=%b addr=%h wdata=%h txd=%h, required all zero",
                     sif.bus_req, sif.bus_we, sif.tx_valid, busy, cmd_dropped, sif.bus_addr, sif.bus_wdata, sif.tx_data);
        end
        #4 rst = 1'b0;
        tick();
    endtask

    task automatic test_write;
        string exp;
        exp = "OK\r\n";
        start_cmd(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 16'h0000);
        checks++;
        if (busy !== 1'b1 || sif.bus_req !== 1'b1 || sif.bus_we !== 1'b1 ||
            sif.bus_addr !== 32'h0000_1000 || sif.bus_wdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL write_bus_fields: busy=%b req=%b we=%b addr=%h wdata=%h, required 1 1 1 00001000 deadbeef",
                     busy, sif.bus_req, sif.bus_we, sif.bus_addr, sif.bus_wdata);
        end
        run_bus(4);
        checks++;
        if (bus_cnt != 4) begin
            failures++;
            $display("FAIL write_req_cycles: got %0d, required 4", bus_cnt);
        end
        checks++;
        if (sif.bus_req !== 1'b0 || sif.tx_valid !== 1'b1 || sif.tx_data !== 8'h4F) begin
            failures++;
            $display("FAIL write_first_byte: req=%b valid=%b data=%h, required 0 1 4f",
                     sif.bus_req, sif.tx_valid, sif.tx_data);
        end
        recv(4, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++;
                $display("FAIL write_byte%0d: got %h, required %h", i, got[i], exp[i]);
            end
        end
        checks++;
        if (ncyc != 4 || busy !== 1'b0 || sif.tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL write_end: cycles=%0d busy=%b valid=%b, required 4 0 0", ncyc, busy, sif.tx_valid);
        end
    endtask

    task automatic test_read;
        string exp;
        exp = "0x0123ABCD\r\n";
        sif.bus_rdata = 32'h0123_ABCD;
        start_cmd(1'b0, 32'h0000_2000, 32'h0, 1'b0, 16'h0000);
        run_bus(1);
        checks++;
        if (bus_cnt != 1) begin
            failures++;
            $display("FAIL read_req_cycles: got %0d, required 1", bus_cnt);
        end
        recv(12, 0);
        checks++;
        if (ngot != 12 || ncyc != 12) begin
            failures++;
            $display("FAIL read_count: bytes=%0d cycles=%0d, required 12 12", ngot, ncyc);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++;
                $display("FAIL read_byte%0d: got %h, required %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_decode_err;
        string exp;
        exp = "E30\r\n";
        start_cmd(1'b1, 32'h0000_3000, 32'h1, 1'b1, {ASCII_0, 8'h33});
        checks++;
        if (sif.tx_valid !== 1'b1 || busy !== 1'b1 || sif.bus_req !== 1'b0) begin
            failures++;
            $display("FAIL derr_start: valid=%b busy=%b req=%b, required 1 1 0", sif.tx_valid, busy, sif.bus_req);
        end
        recv(5, 0);
        checks++;
        if (saw_req != 0 || ngot != 5) begin
            failures++;
            $display("FAIL derr_no_bus: req_cycles=%0d bytes=%0d, required 0 5", saw_req, ngot);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++;
                $display("FAIL derr_byte%0d: got %h, required %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_timeout;
        string exp;
        exp = "E50\r\n";
        start_cmd(1'b0, 32'h0000_4000, 32'h0, 1'b0, 16'h0000);
        run_bus(0);
        checks++;
        if (bus_cnt != 8) begin
            failures++;
            $display("FAIL tmo_req_cycles: got %0d, required 8", bus_cnt);
        end
        recv(5, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++;
                $display("FAIL tmo_byte%0d: got %h, required %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_timeout_ack_last;
        string exp;
        exp = "0xFEDC0089\r\n";
        sif.bus_rdata = 32'hFEDC_0089;
        start_cmd(1'b0, 32'h0000_5000, 32'h0, 1'b0, 16'h0000);
        run_bus(8);
        checks++;
        if (bus_cnt != 8) begin
            failures++;
            $display("FAIL ackl_req_cycles: got %0d, required 8", bus_cnt);
        end
        recv(12, 0);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++;
                $display("FAIL ackl_byte%0d: got %h, required %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        string exp;
        exp = "0x89AB4567\r\n";
        sif.bus_rdata = 32'h89AB_4567;
        start_cmd(1'b0, 32'h0000_6000, 32'h0, 1'b0, 16'h0000);
        run_bus(2);
        recv(12, 1);
        checks++;
        if (unstable != 0 || ngot != 12 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall: unstable=%0d bytes=%0d busy=%b, required 0 12 0", unstable, ngot, busy);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++;
                $display("FAIL bp_byte%0d: got %h, required %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_drop;
        string exp;
        exp = "OK\r\n";
        checks++;
        if (cmd_dropped !== 1'b0) begin
            failures++;
            $display("FAIL drop_initial: got %b, required 0", cmd_dropped);
        end
        start_cmd(1'b1, 32'h0000_7000, 32'hCAFE_F00D, 1'b0, 16'h0000);
        start_cmd(1'b0, 32'h0000_9999, 32'h1111_2222, 1'b0, 16'h0000);
        checks++;
        if (cmd_dropped !== 1'b1 || sif.bus_req !== 1'b1 || sif.bus_we !== 1'b1 ||
            sif.bus_addr !== 32'h0000_7000 || sif.bus_wdata !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL drop_state: drop=%b req=%b we=%b addr=%h wdata=%h, required 1 1 1 00007000 cafef00d",
                     cmd_dropped, sif.bus_req, sif.bus_we, sif.bus_addr, sif.bus_wdata);
        end
        run_bus(2);
        recv(4, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++;
                $display("FAIL drop_byte%0d: got %h, required %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_resp;
        string exp;
        exp = "OK\r\n";
        sif.bus_rdata = 32'h5555_AAAA;
        start_cmd(1'b0, 32'h0000_8000, 32'h0, 1'b0, 16'h0000);
        run_bus(1);
        recv(3, 0);
        sif.tx_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sif.bus_req, sif.bus_we, sif.tx_valid, busy, cmd_dropped} !== 5'b0 ||
            sif.tx_data !== 8'd0 || sif.bus_addr !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_resp: req=%b we=%b valid=%b busy=%b drop=%b txd=%h addr=%h, required all zero",
                     sif.bus_req, sif.bus_we, sif.tx_valid, busy, cmd_dropped, sif.tx_data, sif.bus_addr);
        end
        #1 rst = 1'b0;
        sif.tx_ready = 1'b1;
        tick();
        start_cmd(1'b1, 32'h0000_A000, 32'h0BAD_CAFE, 1'b0, 16'h0000);
        run_bus(3);
        checks++;
        if (bus_cnt != 3) begin
            failures++;
            $display("FAIL rst_next_req: got %0d, required 3", bus_cnt);
        end
        recv(4, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++;
                $display("FAIL rst_next_byte%0d: got %h, required %h", i, got[i], exp[i]);
            end
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        sm_start      = 1'b0;
        addr          = 32'd0;
        wrdata        = 32'd0;
        we            = 1'b0;
        decode_err    = 1'b0;
        err_code      = 16'd0;
        sif.bus_ack   = 1'b0;
        sif.bus_rdata = 32'd0;
        sif.tx_ready  = 1'b1;

        test_reset();
        test_write();
        test_read();
        test_decode_err();
        test_timeout();
        test_timeout_ack_last();
        test_backpressure();
        test_drop();
        test_reset_mid_resp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cmd_sequencer.md
# cmd_sequencer

Backend sequencer of the UART controller. It consumes one decoded command per `sm_start` pulse from the instruction decoder and executes it as a single read or write on a simple request/acknowledge bus master port, with a timeout. It then serialises the ASCII response (`OK`, hex read data, or an error code) byte-by-byte into the UART transmit path over a valid/ready handshake.

## Interface
- `TIMEOUT_CYC`, default 256: cycles `bus_req` may stay high without `bus_ack` before the transaction is abandoned; legal range 2..65535.
- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sm_start`  in  1  one-cycle pulse: the command fields below are valid this cycle.
- `addr`  in  32  decoded address.
- `wrdata`  in  32  decoded write data.
- `we`  in  1  1 = write command, 0 = read command.
- `decode_err`  in  1  command malformed; skip the bus and report `err_code`.
- `err_code`  in  16  two ASCII digits; `[7:0]` is printed first, `[15:8]` second.
- `bus_req`  out  1  transaction request; held until ack or timeout.
- `bus_we`  out  1  write qualifier.
- `bus_addr`  out  32  transaction address.
- `bus_wdata`  out  32  write data.
- `bus_ack`  in  1  slave accepts/completes; carries `bus_rdata` for reads.
- `bus_rdata`  in  32  read data, valid with `bus_ack`.
- `tx_data`  out  8  response byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  transmitter accepts byte when `tx_valid & tx_ready`.
- `busy`  out  1  high whenever state is not IDLE.
- `cmd_dropped`  out  1  sticky; set when `sm_start` arrives while busy; cleared only by reset.

## Operation
- States: IDLE, BUS, RESP.
- **IDLE**
  - On `sm_start`, capture `addr`, `wrdata`, `we` and `err_code`.
  - If `decode_err` is high: resp_type = DERR, go to RESP.
  - Otherwise go to BUS.
- **BUS**
  - `bus_req`=1; `bus_we`/`bus_addr`/`bus_wdata` are driven from the captured fields and held stable.
  - On `bus_ack`: for reads, capture `bus_rdata`; resp_type = WOK (write) or RDAT (read); go to RESP.
  - A timeout counter clears on BUS entry and increments each BUS cycle without ack.
  - When the counter reaches `TIMEOUT_CYC-1` without ack: resp_type = TMO, go to RESP.
  - Ack in the final timeout cycle wins over timeout.
- **RESP**
  - `tx_valid`=1; `tx_data` = response byte at the current byte index.
  - On `tx_valid & tx_ready`, the index increments.
  - Acceptance of the last byte returns to IDLE with the index cleared.
- Response strings:
  - DERR: `E`, `err_code[7:0]`, `err_code[15:8]`, CR, LF (5 bytes).
  - WOK: `O`, `K`, CR, LF (4 bytes).
  - RDAT: `0`, `x`, then 8 uppercase hex digits of the read data MSB nibble first, CR, LF (12 bytes).
  - TMO: `E`, `5`, `0`, CR, LF (5 bytes).
- `sm_start` outside IDLE: the command is ignored, `cmd_dropped` is set, and the current operation is unaffected.
- Byte index is 4 bits wide and never exceeds length−1. Timeout counter is 16 bits.

## Timing
- Reset values: `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, `cmd_dropped`=0, state IDLE.
- `sm_start` at cycle N leads to `busy`=1 at N+1, and either `bus_req`=1 at N+1 or (DERR) `tx_valid`=1 at N+1.
- `bus_ack` may arrive in the first `bus_req` cycle. In the ack cycle `bus_req` is still 1; it is 0 the next cycle, and `tx_valid` rises that same next cycle.
- Timeout: with no ack, `bus_req` is high for exactly `TIMEOUT_CYC` cycles.
- `tx_data` is stable while `tx_valid & !tx_ready`. `tx_valid` never drops before acceptance.
- Back-to-back bytes are possible: one byte per cycle when `tx_ready` is held high.
- After the last byte is accepted, `busy`=0 the next cycle, and `sm_start` is accepted in that cycle.
- All outputs are registered. There is no combinational path from `tx_ready` or `bus_ack` to any output.
- `rst` mid-operation abandons the transaction immediately (asynchronously); no partial response is resumed.

## Structure
- `comm_defs_pkg` gains:
  - state enum `seq_state_t` {IDLE, BUS, RESP};
  - resp-type enum {DERR, WOK, RDAT, TMO};
  - `ASCII_E`, `ASCII_O`, `ASCII_K` and `ASCII_A`..`ASCII_F`, plus existing `ASCII_CR`/`ASCII_LF`;
  - function `num_to_ascii` (4-bit value to uppercase hex char), the inverse of `ascii_to_num`.
- No sub-module. The response byte mux is combinational logic inside the block, feeding the `tx_data` register.

## Test plan
- Write, ack after 3 cycles: `sm_start`, `we`=1, `addr`=0x0000_1000, `wrdata`=0xDEAD_BEEF, `tx_ready`=1.
  - `bus_req` high 4 cycles with `bus_we`=1 and matching addr/wdata.
  - Then bytes 4F 4B 0D 0A on consecutive cycles; `busy` low after.
- Read, ack in first cycle with `bus_rdata`=0x0123_ABCD.
  - TX bytes "0x0123ABCD" then 0D 0A (12 bytes).
- Decode error: `decode_err`=1, `err_code`={ASCII_0,ASCII_3}.
  - `bus_req` never asserts; TX bytes 45 33 30 0D 0A ("E30").
- Timeout: `TIMEOUT_CYC`=8, read, no ack.
  - `bus_req` high exactly 8 cycles, then "E50" CR LF.
  - Repeat with ack in cycle 8: RDAT response, not TMO.
- Backpressure: toggle `tx_ready` 1-of-3 cycles during a read response.
  - `tx_data` is stable while stalled; all 12 bytes arrive in order, none duplicated.
- `sm_start` during BUS: `cmd_dropped`=1, first command completes unaltered.
- `rst` pulse mid-RESP: all outputs 0 immediately; the next command executes normally.
